// File: rtl/draw_pkg.sv
// draw_pkg: shared writer-side definitions for the draw path.
package draw_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
    localparam int PIX_PER_WORD = 4;
    localparam int PIX_BITS = 4;
    // The leftmost pixel of a word lives in the high nibble.
    function automatic logic [PIX_PER_WORD-1:0] nibble_bit(input logic [1:0] n);
        return 4'b1000 >> n;
    endfunction
endpackage

// File: rtl/draw_span_writer.sv
// draw_span_writer: packs a clipped 4bpp pixel stream into masked 16-bit VRAM word writes.
module draw_span_writer
    import draw_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int ADDRW = 16
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [ADDRW-1:0]        base_addr_i,
    input  logic signed [CORDW-1:0] width_i,
    input  logic [PIX_BITS-1:0]     color_i,
    input  logic signed [CORDW-1:0] x_i,
    input  logic                    drawing_i,
    input  logic                    done_i,
    output logic                    oe_o,
    output logic                    vram_wr_o,
    output logic [ADDRW-1:0]        vram_addr_o,
    output logic [15:0]             vram_data_o,
    output logic [3:0]              vram_mask_o,
    input  logic                    vram_ack_i,
    output logic                    busy_o,
    output logic                    done_o
);
    state_t state_q, state_d;
    logic [ADDRW-1:0] base_q, base_d, addr_q, addr_d;
    logic signed [CORDW-1:0] width_q, width_d, cur_q, cur_d, word, cur_n;
    logic [15:0] data_q, data_d;
    logic [3:0] acc_q, acc_d, mask_q, mask_d, acc_n;
    logic wr_q, wr_d, last_q, last_d, end_q, end_d, busy_q, busy_d, done_q, done_d, oe_q, oe_d;
    logic hit, flush, fin;

    assign word  = x_i >>> 2;
    assign hit   = drawing_i && !x_i[CORDW-1] && (x_i < width_q);
    assign flush = hit && (acc_q != 4'b0) && (word != cur_q);
    assign acc_n = hit ? (acc_q | nibble_bit(x_i[1:0])) : acc_q;
    assign cur_n = hit ? word : cur_q;
    assign fin   = end_q || done_i;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        width_d = width_q;
        data_d  = data_q;
        cur_d   = cur_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        wr_d    = wr_q;
        last_d  = last_q;
        end_d   = end_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = COLLECT;
                busy_d  = 1'b1;
                acc_d   = 4'b0;
                end_d   = 1'b0;
                base_d  = base_addr_i;
                width_d = width_i;
                data_d  = {PIX_PER_WORD{color_i}};
            end
            COLLECT: if (flush) begin
                // Word change: emit the finished word, the new pixel starts the next one.
                addr_d  = base_q + ADDRW'(cur_q);
                mask_d  = acc_q;
                acc_d   = nibble_bit(x_i[1:0]);
                cur_d   = word;
                wr_d    = 1'b1;
                last_d  = 1'b0;
                end_d   = fin;
                state_d = WRITE;
            end else begin
                acc_d = acc_n;
                cur_d = cur_n;
                if (fin && acc_n != 4'b0) begin
                    addr_d  = base_q + ADDRW'(cur_n);
                    mask_d  = acc_n;
                    acc_d   = 4'b0;
                    wr_d    = 1'b1;
                    last_d  = 1'b1;
                    end_d   = 1'b0;
                    state_d = WRITE;
                end else if (fin) begin
                    end_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                end_d = end_q || done_i;
                if (vram_ack_i) begin
                    wr_d    = 1'b0;
                    busy_d  = !last_q;
                    done_d  = last_q;
                    state_d = last_q ? IDLE : COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
        oe_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            width_q <= '0;
            data_q  <= '0;
            cur_q   <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            wr_q    <= 1'b0;
            last_q  <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            width_q <= width_d;
            data_q  <= data_d;
            cur_q   <= cur_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
        end
    end

    assign oe_o        = oe_q;
    assign vram_wr_o   = wr_q;
    assign vram_addr_o = addr_q;
    assign vram_data_o = data_q;
    assign vram_mask_o = mask_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
endmodule

// File: tb/tb_draw_span_writer.sv
// tb_draw_span_writer: random and directed spans scored against a word-grouping reference model.
module tb_draw_span_writer;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic start_i = 1'b0, drawing_i = 1'b0, done_i = 1'b0, vram_ack_i = 1'b0;
    logic [15:0] base_addr_i = '0;
    logic signed [15:0] width_i = '0, x_i = '0;
    logic [3:0] color_i = '0;
    logic oe_o, vram_wr_o, busy_o, done_o;
    logic [15:0] vram_addr_o, vram_data_o;
    logic [3:0] vram_mask_o;

    typedef struct packed {logic [15:0] addr; logic [15:0] data; logic [3:0] mask;} wr_t;
    wr_t exp_q[$];
    int vectors = 0, errors = 0, done_cnt = 0;
    int min_delay = 0, max_delay = 3;
    bit always_ack = 0, hold_ack = 0;

    draw_span_writer #(.CORDW(16), .ADDRW(16)) dut (
        .clk(clk), .reset_i(reset_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .width_i(width_i), .color_i(color_i), .x_i(x_i), .drawing_i(drawing_i), .done_i(done_i),
        .oe_o(oe_o), .vram_wr_o(vram_wr_o), .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o),
        .vram_mask_o(vram_mask_o), .vram_ack_i(vram_ack_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: keep visible pixels in stream order, then each run of equal words is one write.
    function automatic void model(input logic [15:0] base, input int width, input logic [3:0] color, input int xs[$]);
        int words[$];
        logic [3:0] bits[$];
        int i = 0;
        foreach (xs[k]) if (xs[k] >= 0 && xs[k] < width) begin
            words.push_back(xs[k] / 4);
            bits.push_back(4'b1000 >> (xs[k] % 4));
        end
        while (i < words.size()) begin
            int w = words[i];
            logic [3:0] m = '0;
            while (i < words.size() && words[i] == w) begin
                m |= bits[i];
                i++;
            end
            exp_q.push_back('{base + 16'(w), {4{color}}, m});
        end
    endfunction

    initial begin : monitor
        bit in_req = 0;
        int wait_n = 0;
        wr_t cur, e;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                in_req = 0;
                vram_ack_i = 1'b0;
                continue;
            end
            if (done_o) done_cnt++;
            if (vram_wr_o) begin
                if (!in_req) begin
                    in_req = 1;
                    cur = '{vram_addr_o, vram_data_o, vram_mask_o};
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_write: got %h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("write", cur, e);
                    end
                    wait_n = $urandom_range(max_delay, min_delay);
                end else check("write_hold", {vram_addr_o, vram_data_o, vram_mask_o}, cur);
                check("oe_in_write", 40'(oe_o), 40'd0);
                vram_ack_i = !hold_ack && (always_ack || wait_n == 0);
                if (wait_n > 0) wait_n--;
            end else begin
                in_req = 0;
                vram_ack_i = always_ack && !hold_ack;
            end
        end
    end

    task automatic run_span(input logic [15:0] base, input int width, input logic [3:0] color,
                            input int xs[$], input bit done_with_last, input bit abort);
        int i = 0, guard = 0, dc;
        bit sent_done = 0;
        model(base, width, color, xs);
        dc = done_cnt;
        @(negedge clk);
        base_addr_i = base;
        width_i = 16'(width);
        color_i = color;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        base_addr_i = 16'($urandom);
        color_i = 4'($urandom);
        while (i < xs.size() && guard < 2000 && !(abort && vram_wr_o)) begin
            if (oe_o && $urandom_range(3, 0) != 0) begin
                drawing_i = 1'b1;
                x_i = 16'(xs[i]);
                i++;
                done_i = done_with_last && i == xs.size();
                sent_done = done_i;
            end else begin
                drawing_i = 1'b0;
                x_i = 16'($urandom);
                done_i = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        drawing_i = 1'b0;
        done_i = 1'b0;
        if (abort) begin
            #2 reset_i = 1'b1;
            #1 check("reset_async", {37'd0, vram_wr_o, busy_o, oe_o}, 40'd0);
            exp_q.delete();
            @(negedge clk);
            reset_i = 1'b0;
            hold_ack = 0;
            return;
        end
        if (!sent_done) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            done_i = 1'b1;
            @(negedge clk);
            done_i = 1'b0;
        end
        guard = 0;
        while (done_cnt == dc && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", 40'(done_cnt - dc), 40'd1);
        check("writes_left", 40'(exp_q.size()), 40'd0);
        check("busy_after", 40'(busy_o), 40'd0);
        exp_q.delete();
    endtask

    function automatic void fill(output int xs[$], input int a, input int b);
        xs.delete();
        if (a <= b) for (int v = a; v <= b; v++) xs.push_back(v);
        else for (int v = a; v >= b; v--) xs.push_back(v);
    endfunction

    initial begin : stim
        int xs[$];
        repeat (2) @(negedge clk);
        check("reset_outs", {vram_addr_o, vram_data_o, 4'd0, oe_o, vram_wr_o, busy_o, done_o},
              40'd0);
        check("reset_mask", 40'(vram_mask_o), 40'd0);
        reset_i = 1'b0;
        always_ack = 1;
        fill(xs, 0, 3);   run_span(16'h1000, 320, 4'hA, xs, 0, 0);
        always_ack = 0;
        fill(xs, 2, 9);   run_span(16'h1000, 320, 4'hA, xs, 1, 0);
        fill(xs, -3, 1);  run_span(16'h1000, 320, 4'h5, xs, 0, 0);
        fill(xs, 318, 325); run_span(16'h1000, 320, 4'h3, xs, 1, 0);
        fill(xs, -6, -1); run_span(16'h2000, 320, 4'h7, xs, 0, 0);
        min_delay = 5;
        max_delay = 5;
        fill(xs, 0, 7);   run_span(16'h0400, 320, 4'hC, xs, 0, 0);
        min_delay = 0;
        max_delay = 3;
        for (int n = 0; n < 40; n++) begin
            int w = $urandom_range(40, 1);
            int len = $urandom_range(16, 0);
            int mode = $urandom_range(2, 0);
            int s = $urandom_range(w + 12, 0) - 6;
            always_ack = ($urandom_range(3, 0) == 0);
            xs.delete();
            for (int k = 0; k < len; k++)
                xs.push_back(mode == 0 ? s + k : mode == 1 ? s - k : $urandom_range(w + 12, 0) - 6);
            run_span(16'($urandom), w, 4'($urandom), xs, len > 0 && $urandom_range(1, 0) == 1, 0);
        end
        always_ack = 0;
        hold_ack = 1;
        fill(xs, 0, 7);   run_span(16'h3000, 320, 4'h9, xs, 0, 1);
        fill(xs, 4, 11);  run_span(16'h3000, 320, 4'h6, xs, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
